// File: rtl/inst_fetch_bridge_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_bridge_pkg
// Shared CPU definitions for the instruction fetch bridge:
//   - fetch_state_e   : FSM state encoding of the fetch bridge
//   - DEF_ADDR_W      : default fetch address width
//   - DEF_DATA_W      : default instruction width
//   - DEF_RESET_ADDR  : reset value of the fetch address register
// -----------------------------------------------------------------------------
package inst_fetch_bridge_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam logic [31:0] DEF_RESET_ADDR = 32'hBFC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DONE    = 3'd3,
        ST_DISCARD = 3'd4
    } fetch_state_e;

endpackage : inst_fetch_bridge_pkg

// File: rtl/inst_fetch_bridge.sv
// -----------------------------------------------------------------------------
// inst_fetch_bridge
// Instruction-side bus master. Turns the pipeline's fetch request into one
// outstanding SRAM-like transaction (req / addr_ok / data_ok), buffers the
// returned word until ID takes it, and raises fetch_stall to hold the PC.
// A flush cancels the fetch; an in-flight transaction is drained silently so
// a stale instruction never reaches the pipeline.
//
// Optional feature: define INST_ALIGN_CHECK_EN to trap misaligned fetch PCs
// (no bus request, instruction returned as 0 with inst_adel=1).
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   if_pc, if_req       fetch address and fetch request from the PC stage
//   if_stall            ID cannot accept an instruction this cycle
//   flush               redirect/exception, kills the current fetch
//   fetch_stall         PC must hold (PC enable = !fetch_stall)
//   inst_valid/_rdata   instruction handed to IF/ID
//   inst_adel           fetch address error flag
//   inst_req/_addr      bus request and address
//   inst_addr_ok        bus accepted the address
//   inst_data_ok        bus returns data on inst_bus_rdata
//   dbg_state           current FSM state, for observation only
//
// Handshake: an address is transferred on a cycle with inst_req & inst_addr_ok;
// inst_req and inst_addr stay constant from the first request cycle until that
// transfer. Exactly one inst_data_ok follows each transferred address.
// -----------------------------------------------------------------------------
module inst_fetch_bridge
    import inst_fetch_bridge_pkg::*;
#(
    parameter int unsigned       ADDR_W     = DEF_ADDR_W,
    parameter int unsigned       DATA_W     = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = DEF_RESET_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              if_req,
    input  logic              if_stall,
    input  logic              flush,
    output logic              fetch_stall,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_adel,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_bus_rdata,
    output fetch_state_e      dbg_state
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              valid_q;
    logic              req_q;
    // Set when a flush hits while the address is still waiting for addr_ok;
    // the transaction it belongs to must be drained, not delivered.
    logic              kill_q;

`ifdef INST_ALIGN_CHECK_EN
    logic              adel_q;
    logic              misaligned;
    assign misaligned = (if_pc[1:0] != 2'b00);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= RESET_ADDR;
            rdata_q <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            kill_q  <= 1'b0;
`ifdef INST_ALIGN_CHECK_EN
            adel_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (if_req && !flush) begin
`ifdef INST_ALIGN_CHECK_EN
                        if (misaligned) begin
                            // Trap without touching the bus.
                            state_q <= ST_DONE;
                            valid_q <= 1'b1;
                            adel_q  <= 1'b1;
                            rdata_q <= '0;
                        end else
`endif
                        begin
                            addr_q  <= if_pc;
                            req_q   <= 1'b1;
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // The request cannot be withdrawn, so a flush here only
                    // marks the transaction for draining.
                    if (inst_addr_ok) begin
                        req_q   <= 1'b0;
                        state_q <= (flush || kill_q) ? ST_DISCARD : ST_WAIT;
                    end else if (flush) begin
                        kill_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (inst_data_ok) begin
                        if (!flush) begin
                            rdata_q <= inst_bus_rdata;
                            valid_q <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (flush) begin
                        state_q <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (inst_data_ok) begin
                        state_q <= ST_IDLE;
                        kill_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (!if_stall || flush) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
`ifdef INST_ALIGN_CHECK_EN
                        adel_q  <= 1'b0;
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign inst_req    = req_q;
    assign inst_addr   = addr_q;
    assign inst_rdata  = rdata_q;
    // A flush in the handover cycle must not let the instruction through.
    assign inst_valid  = valid_q & ~flush;
    assign fetch_stall = if_req & ~((state_q == ST_DONE) & ~if_stall & ~flush);
    assign dbg_state   = state_q;

`ifdef INST_ALIGN_CHECK_EN
    assign inst_adel = adel_q;
`else
    assign inst_adel = 1'b0;
`endif

`ifndef SYNTHESIS
    // Data may only return for an address the bus has already accepted.
    data_ok_not_in_req: assert property (
        @(posedge clk) disable iff (!rst) !((state_q == ST_REQ) && inst_data_ok)
    );
`endif

endmodule : inst_fetch_bridge

// File: tb/tb_inst_fetch_bridge.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_bridge
// Self-checking bench for inst_fetch_bridge. A transaction-level model
// (pending address, outstanding transfer, doomed flag, held-word queue)
// predicts every output each cycle; directed scenarios add literal checks,
// then a randomized phase drives a protocol-correct bus responder.
// Honours INST_ALIGN_CHECK_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_inst_fetch_bridge;
    import inst_fetch_bridge_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] if_pc;
    logic          if_req;
    logic          if_stall;
    logic          flush;
    logic          fetch_stall;
    logic          inst_valid;
    logic [DW-1:0] inst_rdata;
    logic          inst_adel;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [DW-1:0] inst_bus_rdata;
    fetch_state_e  dbg_state;

    inst_fetch_bridge dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_req         (if_req),
        .if_stall       (if_stall),
        .flush          (flush),
        .fetch_stall    (fetch_stall),
        .inst_valid     (inst_valid),
        .inst_rdata     (inst_rdata),
        .inst_adel      (inst_adel),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_bus_rdata (inst_bus_rdata),
        .dbg_state      (dbg_state)
    );

    // ---------------- counters ----------------
    int checks = 0;
    int passed = 0;
    int handovers = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model / scoreboard ----------------
    bit          m_pending;  // address waiting to be accepted by the bus
    bit          m_outst;    // address accepted, data still to come
    bit          m_doomed;   // flushed transaction: its data must be dropped
    bit          m_adel;     // held word is an address-error trap
    logic [31:0] m_addr;
    logic [DW-1:0] exp_q[$]; // word waiting for ID (at most one)

    task automatic model_reset();
        m_pending = 1'b0;
        m_outst   = 1'b0;
        m_doomed  = 1'b0;
        m_adel    = 1'b0;
        m_addr    = 32'hBFC0_0000;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        bit held;
        held = (exp_q.size() != 0);
        chk1("inst_req", inst_req, m_pending);
        if (m_pending) chk32("inst_addr", inst_addr, m_addr);
        chk1("inst_valid", inst_valid, held && !flush);
        chk1("fetch_stall", fetch_stall, if_req && !(held && !if_stall && !flush));
        chk1("inst_adel", inst_adel, held && m_adel);
        if (held) chk32("inst_rdata", inst_rdata, exp_q[0]);
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_update();
        bit misaligned;
        if (!rst) return;
        if (exp_q.size() != 0) begin
            if (!if_stall || flush) begin
                if (!flush) handovers++;
                void'(exp_q.pop_front());
                m_adel = 1'b0;
            end
        end else if (m_pending) begin
            if (inst_addr_ok) begin
                m_pending = 1'b0;
                m_outst   = 1'b1;
                m_doomed  = m_doomed | flush;
            end else if (flush) begin
                m_doomed = 1'b1;
            end
        end else if (m_outst) begin
            if (inst_data_ok) begin
                m_outst = 1'b0;
                if (!m_doomed && !flush) exp_q.push_back(inst_bus_rdata);
                m_doomed = 1'b0;
            end else if (flush) begin
                m_doomed = 1'b1;
            end
        end else if (if_req && !flush) begin
            misaligned = 1'b0;
`ifdef INST_ALIGN_CHECK_EN
            misaligned = (if_pc[1:0] != 2'b00);
`endif
            if (misaligned) begin
                exp_q.push_back('0);
                m_adel = 1'b1;
            end else begin
                m_pending = 1'b1;
                m_addr    = if_pc;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit req, input logic [31:0] pc, input bit stall, input bit fl,
                         input bit aok, input bit dok, input logic [31:0] data);
        if_req         = req;
        if_pc          = pc;
        if_stall       = stall;
        flush          = fl;
        inst_addr_ok   = aok;
        inst_data_ok   = dok;
        inst_bus_rdata = data;
    endtask

    task automatic half();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic finish_cycle();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        half();
        finish_cycle();
    endtask

    // From IDLE: one request cycle, then address accepted; ends in the wait phase.
    task automatic fetch_to_wait(input logic [31:0] pc);
        drive(1, pc, 0, 0, 0, 0, 0);
        half();
        chk1("idle_no_req", inst_req, 1'b0);
        finish_cycle();
        drive(1, pc, 0, 0, 1, 0, 0);
        half();
        chk1("req_high", inst_req, 1'b1);
        chk32("req_addr", inst_addr, pc);
        finish_cycle();
    endtask

    // ---------------- bus responder for the random phase ----------------
    bit bus_busy = 1'b0;
    int bus_delay = 0;

    task automatic bus_update();
        if (inst_data_ok) bus_busy = 1'b0;
        else if (bus_busy && bus_delay > 0) bus_delay--;
        if (inst_req && inst_addr_ok) begin
            bus_busy  = 1'b1;
            bus_delay = $urandom_range(0, 3);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] pc;
        bit aok, dok;

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #27;
        chk1("rst_inst_req", inst_req, 1'b0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk32("rst_inst_rdata", inst_rdata, 32'h0);
        chk1("rst_inst_adel", inst_adel, 1'b0);
        chk32("rst_inst_addr", inst_addr, 32'hBFC0_0000);
        chk32("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b1;

        // 1: minimum-latency fetch
        fetch_to_wait(32'hBFC0_0000);
        drive(1, 32'hBFC0_0000, 0, 0, 0, 1, 32'h3C08_BFC0);
        half();
        chk1("t1_wait_valid", inst_valid, 1'b0);
        chk1("t1_wait_stall", fetch_stall, 1'b1);
        finish_cycle();
        drive(1, 32'hBFC0_0000, 0, 0, 0, 0, 0);
        half();
        chk1("t1_valid", inst_valid, 1'b1);
        chk32("t1_rdata", inst_rdata, 32'h3C08_BFC0);
        chk1("t1_stall_low", fetch_stall, 1'b0);
        chk32("t1_state", 32'(dbg_state), 32'(ST_DONE));
        finish_cycle();
        drive(0, 32'hBFC0_0004, 0, 0, 0, 0, 0);
        half();
        chk1("t1_after_valid", inst_valid, 1'b0);
        finish_cycle();

        // 2: ID stalls 4 cycles while the word is held
        fetch_to_wait(32'hBFC0_0004);
        drive(1, 32'hBFC0_0004, 0, 0, 0, 1, 32'h2408_0001);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'hBFC0_0004, 1, 0, 0, 0, 0);
            half();
            chk1("t2_hold_valid", inst_valid, 1'b1);
            chk32("t2_hold_rdata", inst_rdata, 32'h2408_0001);
            chk1("t2_hold_stall", fetch_stall, 1'b1);
            finish_cycle();
        end
        drive(1, 32'hBFC0_0004, 0, 0, 0, 0, 0);
        half();
        chk1("t2_release_stall", fetch_stall, 1'b0);
        finish_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();

        // 3: flush while waiting for data, data arrives 2 cycles later
        fetch_to_wait(32'hBFC0_0008);
        drive(1, 32'hBFC0_0008, 0, 1, 0, 0, 0);
        half();
        chk1("t3_flush_valid", inst_valid, 1'b0);
        finish_cycle();
        drive(1, 32'hBFC0_0180, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'hBFC0_0180, 0, 0, 0, 1, 32'hDEAD_BEEF);
        half();
        chk1("t3_discard_valid", inst_valid, 1'b0);
        finish_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        half();
        chk1("t3_idle_valid", inst_valid, 1'b0);
        chk32("t3_idle_state", 32'(dbg_state), 32'(ST_IDLE));
        finish_cycle();

        // 4: flush while the address is pending, addr_ok 3 cycles later
        drive(1, 32'hBFC0_0100, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'hBFC0_0100, 0, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'hBFC0_0380, 0, 0, 0, 0, 0);
            half();
            chk1("t4_req_held", inst_req, 1'b1);
            chk32("t4_addr_held", inst_addr, 32'hBFC0_0100);
            finish_cycle();
        end
        drive(1, 32'hBFC0_0380, 0, 0, 1, 0, 0);
        tick();
        drive(1, 32'hBFC0_0380, 0, 0, 0, 1, 32'h1111_1111);
        half();
        chk1("t4_drop_valid", inst_valid, 1'b0);
        finish_cycle();
        fetch_to_wait(32'hBFC0_0380);
        drive(1, 32'hBFC0_0380, 0, 0, 0, 1, 32'h8C02_0000);
        tick();
        drive(1, 32'hBFC0_0380, 0, 0, 0, 0, 0);
        half();
        chk1("t4_valid", inst_valid, 1'b1);
        chk32("t4_rdata", inst_rdata, 32'h8C02_0000);
        finish_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();

        // 5: asynchronous reset in the middle of a transaction
        fetch_to_wait(32'h8000_1230);
        drive(1, 32'h8000_1230, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk1("t5_req", inst_req, 1'b0);
        chk1("t5_valid", inst_valid, 1'b0);
        chk32("t5_rdata", inst_rdata, 32'h0);
        chk1("t5_adel", inst_adel, 1'b0);
        chk32("t5_addr", inst_addr, 32'hBFC0_0000);
        model_reset();
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();

`ifdef INST_ALIGN_CHECK_EN
        // 6: misaligned fetch trapped without a bus request
        drive(1, 32'hBFC0_0002, 0, 0, 0, 0, 0);
        half();
        chk1("t6_no_req0", inst_req, 1'b0);
        finish_cycle();
        drive(1, 32'hBFC0_0002, 0, 0, 0, 0, 0);
        half();
        chk1("t6_no_req1", inst_req, 1'b0);
        chk1("t6_adel", inst_adel, 1'b1);
        chk1("t6_valid", inst_valid, 1'b1);
        chk32("t6_rdata", inst_rdata, 32'h0);
        finish_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
`endif

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            aok = inst_req && ($urandom_range(0, 1) == 1);
            dok = bus_busy && (bus_delay == 0);
            pc  = $urandom;
            if ($urandom_range(0, 9) != 0) pc[1:0] = 2'b00;
            drive($urandom_range(0, 7) != 0, pc, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, aok, dok, $urandom);
            half();
            bus_update();
            finish_cycle();
        end
        chk1("random_handovers_seen", handovers >= 20, 1'b1);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_inst_fetch_bridge
